// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader.
// Build option: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
package imem_loader_pkg;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR0 = 3'd1;
  localparam logic [2:0] S_HDR1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready link feeding the loader.
// Master is the byte source, slave is the loader.
interface imem_loader_if;

  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian stream bytes into 32-bit words.
// word shows the word including the byte accepted this cycle.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  cnt;
  logic [31:0] wreg;

  always_comb begin
    word = wreg;
    if (en) word[{cnt, 3'b000} +: 8] = din;
  end

  assign word_full = en && (cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt  <= '0;
      wreg <= '0;
    end else if (en) begin
      cnt  <= cnt + 2'd1;
      wreg <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: writes instruction memory, holds the core in reset.
// Build option: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      stream,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset_hold,
  output logic              load_done,
  output logic              load_err
);

  logic [2:0]  state;
  logic [15:0] count;
  logic [15:0] widx;
  logic        rdy;
  logic        acc;
  logic        idle;
  logic [15:0] hdr;
  logic [31:0] word;
  logic        wfull;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign stream.byte_ready = rdy;
  assign acc  = stream.byte_valid && rdy;
  assign idle = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign hdr  = {stream.byte_in, count[7:0]};

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (start && idle),
    .en        (acc && (state == S_DATA)),
    .din       (stream.byte_in),
    .word      (word),
    .word_full (wfull)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      count          <= '0;
      widx           <= '0;
      rdy            <= 1'b0;
      imem_we        <= 1'b0;
      imem_addr      <= '0;
      imem_wdata     <= '0;
      cpu_reset_hold <= 1'b1;
      load_done      <= 1'b0;
      load_err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (wfull) begin
        imem_we    <= 1'b1;
        imem_addr  <= widx[ADDR_W-1:0];
        imem_wdata <= word;
        widx       <= widx + 16'd1;
      end
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state          <= S_HDR0;
            count          <= '0;
            widx           <= '0;
            rdy            <= 1'b1;
            cpu_reset_hold <= 1'b1;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum           <= '0;
`endif
          end else if (state == S_DONE) begin
            load_done      <= 1'b1;
            cpu_reset_hold <= 1'b0;
          end else if (state == S_ERR) begin
            load_err <= 1'b1;
          end
        end
        S_HDR0: begin
          if (acc) begin
            count[7:0] <= stream.byte_in;
            state      <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (acc) begin
            count[15:8] <= stream.byte_in;
            if (hdr == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= S_CSUM;
`else
              state <= S_DONE;
              rdy   <= 1'b0;
`endif
            end else if (hdr > 16'(DEPTH)) begin
              state <= S_ERR;
              rdy   <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (acc) csum <= csum ^ stream.byte_in;
          if (wfull && (widx == count - 16'd1)) state <= S_CSUM;
`else
          if (wfull && (widx == count - 16'd1)) begin
            state <= S_DONE;
            rdy   <= 1'b0;
          end
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (acc) begin
            rdy   <= 1'b0;
            state <= (csum == stream.byte_in) ? S_DONE : S_ERR;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, empty, oversize, stalls, reset.
// Define IMEM_LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        imem_we;
  logic [4:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset_hold;
  logic        load_done;
  logic        load_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0]  wa[$];
  logic [31:0] wd[$];
  logic [7:0]  prog [10];

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] cs_flip = 8'h00;
`endif

  imem_loader_if bi ();

  imem_loader #(.ADDR_W(5), .DEPTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stream         (bi),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_wdata     (imem_wdata),
    .cpu_reset_hold (cpu_reset_hold),
    .load_done      (load_done),
    .load_err       (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bi.byte_in    = b;
    bi.byte_valid = 1'b1;
    while (!bi.byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bi.byte_ready) chk("ready_wait", {31'd0, bi.byte_ready}, 32'd1);
    @(posedge clk);
    #1 bi.byte_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, bi.byte_ready}, 32'd0);
    chk({tag, "_we"},    {31'd0, imem_we}, 32'd0);
    chk({tag, "_addr"},  {27'd0, imem_addr}, 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_hold"},  {31'd0, cpu_reset_hold}, 32'd1);
    chk({tag, "_done"},  {31'd0, load_done}, 32'd0);
    chk({tag, "_err"},   {31'd0, load_err}, 32'd0);
  endtask

  task automatic load(input bit gaps);
    logic [7:0] cs;
    cs = 8'h00;
    wa.delete();
    wd.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      send(prog[i]);
      if (i >= 2) cs = cs ^ prog[i];
      if (gaps && i == 5) pulse_start();
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(cs ^ cs_flip);
`endif
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_words(input string tag);
    chk({tag, "_nwr"}, wa.size(), 32'd2);
    if (wa.size() >= 2) begin
      chk({tag, "_a0"}, {27'd0, wa[0]}, 32'd0);
      chk({tag, "_d0"}, wd[0], 32'h00200013);
      chk({tag, "_a1"}, {27'd0, wa[1]}, 32'd1);
      chk({tag, "_d1"}, wd[1], 32'h00420133);
    end
    chk({tag, "_done"}, {31'd0, load_done}, 32'd1);
    chk({tag, "_hold"}, {31'd0, cpu_reset_hold}, 32'd0);
    chk({tag, "_err"},  {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prog = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h20,
             8'h00, 8'h33, 8'h01, 8'h42, 8'h00};
    reset         = 1'b1;
    start         = 1'b0;
    bi.byte_in    = 8'h00;
    bi.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk);
    #1 reset = 1'b0;

    load(1'b0);
    chk_words("s1");

    wa.delete();
    wd.delete();
    pulse_start();
    send(8'h00);
    send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    @(negedge clk);
    chk("s2_hold_early", {31'd0, cpu_reset_hold}, 32'd1);
    chk("s2_done_early", {31'd0, load_done}, 32'd0);
    @(negedge clk);
    chk("s2_done", {31'd0, load_done}, 32'd1);
    chk("s2_hold", {31'd0, cpu_reset_hold}, 32'd0);
    repeat (2) @(negedge clk);
    chk("s2_nwr", wa.size(), 32'd0);

    pulse_start();
    send(8'h21);
    send(8'h00);
    repeat (2) @(negedge clk);
    chk("s3_err",   {31'd0, load_err}, 32'd1);
    chk("s3_hold",  {31'd0, cpu_reset_hold}, 32'd1);
    chk("s3_ready", {31'd0, bi.byte_ready}, 32'd0);
    chk("s3_done",  {31'd0, load_done}, 32'd0);
    load(1'b0);
    chk_words("s3r");

    load(1'b1);
    chk_words("s4");

    pulse_start();
    for (int i = 0; i < 9; i++) send(prog[i]);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("s5");
    @(posedge clk);
    #1 reset = 1'b0;
    load(1'b0);
    chk_words("s5r");

`ifdef IMEM_LOADER_CHECKSUM_EN
    cs_flip = 8'h01;
    load(1'b0);
    chk("s6_err",  {31'd0, load_err}, 32'd1);
    chk("s6_hold", {31'd0, cpu_reset_hold}, 32'd1);
    chk("s6_done", {31'd0, load_done}, 32'd0);
    cs_flip = 8'h00;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
